// File: rtl/dijkstra_path_planner.sv
// ============================================================================
// Module      : dijkstra_path_planner
// Description : Sequential Dijkstra engine over a run-time loaded adjacency
//               matrix; streams the shortest start-to-end node sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dijkstra_path_planner #(
  parameter int N_NODES = 37,
  parameter int NODE_W  = 6,
  parameter int WT_W    = 4,
  parameter int DIST_W  = 12
) (
  input  logic              clk_50,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [NODE_W-1:0] cfg_from,
  input  logic [NODE_W-1:0] cfg_to,
  input  logic [WT_W-1:0]   cfg_wt,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [NODE_W-1:0] req_start,
  input  logic [NODE_W-1:0] req_end,
  output logic              busy,
  output logic              done,
  output logic              no_path,
  output logic [NODE_W:0]   path_len,
  output logic [DIST_W-1:0] path_dist,
  output logic              path_valid,
  input  logic              path_ready,
  output logic [NODE_W-1:0] path_node,
  output logic              path_last
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_INIT   = 3'd1;
  localparam logic [2:0] c_SELECT = 3'd2;
  localparam logic [2:0] c_RELAX  = 3'd3;
  localparam logic [2:0] c_TRACE  = 3'd4;
  localparam logic [2:0] c_EMIT   = 3'd5;

  localparam logic [DIST_W-1:0] c_INF  = '1;
  localparam logic [DIST_W-1:0] c_SAT  = {{(DIST_W-1){1'b1}}, 1'b0};
  localparam logic [NODE_W-1:0] c_LAST = NODE_W'(N_NODES - 1);
  localparam logic [NODE_W-1:0] c_ZERO = '0;
  localparam logic [NODE_W-1:0] c_ONE  = NODE_W'(1);
  localparam logic [NODE_W:0]   c_NN   = (NODE_W + 1)'(N_NODES);

  logic [2:0]        r_state;
  logic [NODE_W-1:0] r_idx;
  logic [NODE_W-1:0] r_start;
  logic [NODE_W-1:0] r_end;
  logic              r_bad;
  logic [NODE_W-1:0] r_u;
  logic [DIST_W-1:0] r_du;
  logic [DIST_W-1:0] r_min_dist;
  logic [NODE_W-1:0] r_min_node;
  logic [NODE_W-1:0] r_cur;
  logic [NODE_W-1:0] r_ptr;

  logic [WT_W-1:0]   r_adj     [N_NODES][N_NODES];
  logic [DIST_W-1:0] r_dist    [N_NODES];
  logic [NODE_W-1:0] r_pred    [N_NODES];
  logic [NODE_W-1:0] r_buf     [N_NODES];
  logic [N_NODES-1:0] r_visited;

  logic              w_cfg_ok;
  logic              w_req_bad;
  logic              w_cand;
  logic [DIST_W-1:0] w_best_dist;
  logic [NODE_W-1:0] w_best_node;
  logic [WT_W-1:0]   w_wt;
  logic [DIST_W:0]   w_sum;
  logic [DIST_W-1:0] w_relax_val;
  logic              w_relax;

  assign req_ready = (r_state == c_IDLE);
  assign busy      = (r_state != c_IDLE);

  assign w_cfg_ok  = ({1'b0, cfg_from} < c_NN) && ({1'b0, cfg_to} < c_NN);
  assign w_req_bad = ({1'b0, req_start} >= c_NN) || ({1'b0, req_end} >= c_NN);

  // Ascending scan with strict compare keeps the lowest index on equal distances
  assign w_cand      = !r_visited[r_idx] && (r_dist[r_idx] < r_min_dist);
  assign w_best_dist = w_cand ? r_dist[r_idx] : r_min_dist;
  assign w_best_node = w_cand ? r_idx : r_min_node;

  // Saturate one below infinity so a relaxed distance is never mistaken for unreachable
  assign w_wt        = r_adj[r_u][r_idx];
  assign w_sum       = {1'b0, r_du} + (DIST_W + 1)'(w_wt);
  assign w_relax_val = (w_sum > {1'b0, c_SAT}) ? c_SAT : w_sum[DIST_W-1:0];
  assign w_relax     = (w_wt != '0) && !r_visited[r_idx] && (w_relax_val < r_dist[r_idx]);

  // Reset also clears the adjacency matrix, so software reloads edges after any reset
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_IDLE;
      r_idx      <= '0;
      r_start    <= '0;
      r_end      <= '0;
      r_bad      <= 1'b0;
      r_u        <= '0;
      r_du       <= '0;
      r_min_dist <= c_INF;
      r_min_node <= '0;
      r_cur      <= '0;
      r_ptr      <= '0;
      r_visited  <= '0;
      done       <= 1'b0;
      no_path    <= 1'b0;
      path_len   <= '0;
      path_dist  <= '0;
      path_valid <= 1'b0;
      path_node  <= '0;
      path_last  <= 1'b0;
      for (int i = 0; i < N_NODES; i++) begin
        r_dist[i] <= c_INF;
        r_pred[i] <= '0;
        r_buf[i]  <= '0;
        for (int j = 0; j < N_NODES; j++) begin
          r_adj[i][j] <= '0;
        end
      end
    end else begin
      done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (cfg_we && w_cfg_ok) begin
            r_adj[cfg_from][cfg_to] <= cfg_wt;
          end
          if (req_valid) begin
            r_start   <= req_start;
            r_end     <= req_end;
            r_bad     <= w_req_bad;
            no_path   <= 1'b0;
            path_len  <= '0;
            path_dist <= '0;
            r_idx     <= '0;
            r_state   <= c_INIT;
          end
        end

        c_INIT: begin
          if (r_bad) begin
            no_path <= 1'b1;
            done    <= 1'b1;
            r_state <= c_IDLE;
          end else begin
            r_dist[r_idx]    <= (r_idx == r_start) ? '0 : c_INF;
            r_visited[r_idx] <= 1'b0;
            r_pred[r_idx]    <= r_idx;
            if (r_idx == c_LAST) begin
              r_idx      <= '0;
              r_min_dist <= c_INF;
              r_min_node <= '0;
              r_state    <= c_SELECT;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end

        c_SELECT: begin
          if (r_idx == c_LAST) begin
            r_idx <= '0;
            if (w_best_dist == c_INF) begin
              no_path <= 1'b1;
              done    <= 1'b1;
              r_state <= c_IDLE;
            end else if (w_best_node == r_end) begin
              r_cur   <= r_end;
              r_state <= c_TRACE;
            end else begin
              r_visited[w_best_node] <= 1'b1;
              r_u     <= w_best_node;
              r_du    <= w_best_dist;
              r_state <= c_RELAX;
            end
          end else begin
            r_min_dist <= w_best_dist;
            r_min_node <= w_best_node;
            r_idx      <= r_idx + 1'b1;
          end
        end

        c_RELAX: begin
          if (w_relax) begin
            r_dist[r_idx] <= w_relax_val;
            r_pred[r_idx] <= r_u;
          end
          if (r_idx == c_LAST) begin
            r_idx      <= '0;
            r_min_dist <= c_INF;
            r_min_node <= '0;
            r_state    <= c_SELECT;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        // Buffer fills end-first; r_ptr ends up on the start node's slot
        c_TRACE: begin
          r_buf[path_len[NODE_W-1:0]] <= r_cur;
          path_len <= path_len + 1'b1;
          if (r_cur == r_start) begin
            path_dist <= r_dist[r_end];
            r_ptr     <= path_len[NODE_W-1:0];
            done      <= 1'b1;
            r_state   <= c_EMIT;
          end else begin
            r_cur <= r_pred[r_cur];
          end
        end

        c_EMIT: begin
          if (!path_valid) begin
            path_valid <= 1'b1;
            path_node  <= r_buf[r_ptr];
            path_last  <= (r_ptr == c_ZERO);
          end else if (path_ready) begin
            if (path_last) begin
              path_valid <= 1'b0;
              path_last  <= 1'b0;
              r_state    <= c_IDLE;
            end else begin
              r_ptr     <= r_ptr - 1'b1;
              path_node <= r_buf[r_ptr - 1'b1];
              path_last <= (r_ptr == c_ONE);
            end
          end
        end

        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/dijkstra_path_planner.md
# dijkstra_path_planner

Multi-cycle, parametrised shortest-path engine for the soil-monitoring bot's arena graph. Holds a weighted adjacency matrix loaded at run time, runs Dijkstra from a requested start node to a requested end node one vertex/edge per clock, and streams the resulting node sequence, start to end, over a valid/ready port. It sits between the task sequencer, which issues node-pair requests, and the turn-command generator, which consumes the node stream.

## Interface
- N_NODES, default 37: number of graph vertices (node ids 0..N_NODES-1).
- NODE_W, default 6: node id width; must satisfy 2^NODE_W >= N_NODES.
- WT_W, default 4: edge weight width; weight 0 = no edge.
- DIST_W, default 12: accumulated distance width; all-ones = infinity.

- clk_50  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  adjacency write strobe.
- cfg_from, cfg_to  in  NODE_W each  edge endpoints for write (directed; both directions written separately).
- cfg_wt  in  WT_W  edge weight.
- req_valid  in  1  path request.
- req_ready  out  1  high only in IDLE.
- req_start, req_end  in  NODE_W each  start and end node, captured on req_valid && req_ready.
- busy  out  1  high from request acceptance until the last path node is accepted.
- done  out  1  one-cycle pulse when result is final (before streaming).
- no_path  out  1  end node unreachable; held until next accepted request.
- path_len  out  NODE_W+1  number of nodes in path including start and end; 0 when no_path.
- path_dist  out  DIST_W  total path weight.
- path_valid  out  1  stream valid.
- path_ready  in  1  stream ready.
- path_node  out  NODE_W  current node id.
- path_last  out  1  asserted with the end node.

## Operation
- States: IDLE, INIT, SELECT, RELAX, TRACE, EMIT.
- IDLE: req_ready=1. cfg_we writes the adjacency matrix entry [cfg_from][cfg_to]; ignored in all other states. Request accepted -> INIT; no_path cleared.
- INIT: N_NODES cycles, one vertex/cycle: dist=inf, visited=0, pred=self; dist[start]=0 on its cycle.
- SELECT: scans all N_NODES vertices, one/cycle; picks the unvisited vertex with minimum dist, ties broken by lowest index. At end of scan: if min dist = inf -> no_path=1, done pulse, IDLE; if selected vertex = end -> TRACE; otherwise mark visited -> RELAX.
- RELAX: scans neighbours j=0..N_NODES-1, one/cycle; if wt[u][j]!=0, j unvisited and dist[u]+wt < dist[j], update dist[j] and pred[j]=u. Strictly-less only (first-found predecessor kept on ties). Addition saturates at all-ones minus 1; an infinite result is never written. -> SELECT.
- TRACE: walks pred from end to start, one hop/cycle, writing nodes into a reverse buffer; path_len counts nodes; path_dist = dist[end]. On reaching start: done pulse -> EMIT.
- EMIT: presents buffer in start-to-end order; advances on path_valid && path_ready; path_last with the end node; handshake on last -> IDLE, busy=0.
- start = end: INIT, one SELECT picks start = end, TRACE of 1 cycle, path_len=1, path_dist=0, single beat with path_last=1.
- Out-of-range node ids (>= N_NODES) in a request: request accepted, immediate no_path=1 and done after one cycle, back to IDLE.

## Timing
- Reset values: state IDLE, req_ready=1, busy=0, done=0, no_path=0, path_len=0, path_dist=0, path_valid=0, path_node=0, path_last=0; adjacency matrix cleared to 0 (or reloaded by software before first request).
- Latency request accept -> done: N_NODES (INIT) + k·(2·N_NODES) + N_NODES (final SELECT) + path_len, where k = vertices relaxed before the end node is selected.
- path_valid rises the cycle after done; node held stable while path_ready low.
- rst_n asserted mid-operation: immediate return to reset values, stream dropped; adjacency contents preserved unless reset clears them per implementation choice, which must be documented in code.
- cfg_we and req_valid in the same IDLE cycle: write completes; request sees the new weight.

## Test plan
- Line graph N=8, edges 0-1-2-3 weight 1 each, request 0->3 -> done, path_len=4, path_dist=3, stream 0,1,2,3 with path_last on 3.
- Diamond: 0-1 w1, 1-3 w5, 0-2 w2, 2-3 w1; request 0->3 -> path 0,2,3, path_dist=3; equal-cost variant (2-3 w4) -> path 0,1,3 (lowest-index tie).
- Disconnected node 5, request 0->5 -> no_path=1, path_len=0, no path_valid beats, req_ready back high.
- Request 4->4 -> path_len=1, path_dist=0, one beat node 4, path_last=1.
- Backpressure: hold path_ready low 10 cycles mid-stream -> path_node stable, no beat lost or duplicated.
- Assert rst_n low during RELAX -> all outputs at reset values next cycle; fresh request afterwards completes correctly.
